// File: rtl/board_status_ctrl.sv
// Board supervisor: button debounce, PLL-lock reset sequencing, heartbeat and per-channel LED modes.
// Optional feature: define LED_LOCKLOSS_EN to add a sticky lock-loss indicator on the top LED.
module board_status_ctrl #(
    parameter int unsigned NUM_LEDS        = 4,
    parameter int unsigned HB_BIT          = 23,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned PWM_BITS        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_locked,
    input  logic                  btn_in,
    input  logic [NUM_LEDS-1:0]   cpu_leds,
    input  logic [2*NUM_LEDS-1:0] led_mode,
    input  logic [PWM_BITS-1:0]   pwm_duty,
    output logic                  cpu_rst,
    output logic                  hb_out,
    output logic [NUM_LEDS-1:0]   led,
    output logic [1:0]            rst_state
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned CNT_W  = HB_BIT + 1;

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_WAIT = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    logic              btn_meta;
    logic              btn_sync;
    logic              btn_db;
    logic [DB_W-1:0]   db_cnt;

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              abort;

    logic [CNT_W-1:0]    hb_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] led_d;

    // Synchronizer plus debounce: accept a new level only after it persists.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Reset sequencer state register; cpu_rst follows next-state so both move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            cpu_rst <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cpu_rst <= (state_d != ST_RUN);
        end
    end

    // Reset sequencer next-state: any abort falls back to HOLD and restarts the hold-off.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        abort   = !clk_locked || btn_db;
        case (state_q)
            ST_HOLD: begin
                if (clk_locked && !btn_db) begin
                    state_d = ST_WAIT;
                    hold_d  = HOLD_W'(RST_HOLD_CYCLES - 1);
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_HOLD;
                end else if (hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    assign rst_state = state_q;

    // Free-running heartbeat and PWM counters; they ignore cpu_rst so the clock is always visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt  <= '0;
            pwm_cnt <= '0;
            hb_out  <= 1'b0;
        end else begin
            hb_cnt  <= hb_cnt + CNT_W'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            hb_out  <= hb_cnt[HB_BIT];
        end
    end

    assign pwm_on = (pwm_cnt < pwm_duty);

`ifdef LED_LOCKLOSS_EN
    logic lockloss_q;

    // Sticky: once lock drops while running, only a full reset clears the indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            lockloss_q <= 1'b0;
        end else if (!clk_locked && (state_q == ST_RUN)) begin
            lockloss_q <= 1'b1;
        end
    end
`endif

    // Per-channel mode decode; CPU-driven modes stay dark while the CPU is held in reset.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (led_mode[2*i +: 2])
                2'd0:    led_d[i] = 1'b0;
                2'd1:    led_d[i] = cpu_leds[i] & !cpu_rst;
                2'd2:    led_d[i] = hb_cnt[HB_BIT];
                default: led_d[i] = cpu_leds[i] & pwm_on & !cpu_rst;
            endcase
        end
`ifdef LED_LOCKLOSS_EN
        if (lockloss_q) begin
            led_d[NUM_LEDS-1] = hb_cnt[HB_BIT-2];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end

endmodule

// File: tb/tb_board_status_ctrl.sv
// Scoreboard bench for board_status_ctrl: directed stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_board_status_ctrl;

    localparam int unsigned NL = 4;
    localparam int unsigned HB = 3;
    localparam int unsigned DB = 8;
    localparam int unsigned RH = 16;
    localparam int unsigned PB = 4;

    logic          clk;
    logic          rst;
    logic          clk_locked;
    logic          btn_in;
    logic [NL-1:0] cpu_leds;
    logic [2*NL-1:0] led_mode;
    logic [PB-1:0] pwm_duty;
    logic          cpu_rst;
    logic          hb_out;
    logic [NL-1:0] led;
    logic [1:0]    rst_state;

    board_status_ctrl #(
        .NUM_LEDS(NL),
        .HB_BIT(HB),
        .DEBOUNCE_CYCLES(DB),
        .RST_HOLD_CYCLES(RH),
        .PWM_BITS(PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_locked(clk_locked),
        .btn_in(btn_in),
        .cpu_leds(cpu_leds),
        .led_mode(led_mode),
        .pwm_duty(pwm_duty),
        .cpu_rst(cpu_rst),
        .hb_out(hb_out),
        .led(led),
        .rst_state(rst_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;   // 0 cpu_rst, 1 rst_state, 2 led, 3 hb_out
        logic [3:0]  val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    r0 = 0;
`ifdef LED_LOCKLOSS_EN
    logic  lockloss_exp = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_until(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int e, input logic [1:0] kind, input logic [3:0] val,
                             input string nm);
        exp_t x;
        x.cyc  = 32'(e);
        x.kind = kind;
        x.val  = val;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic expect_fsm(input int e, input logic [1:0] st, input logic cr, input string nm);
        expect_at(e, 2'd1, {2'b00, st}, {nm, "_state"});
        expect_at(e, 2'd0, {3'b000, cr}, {nm, "_cpu_rst"});
    endtask

    // Counter value the DUT held just before edge e (counters restart from 0 at edge r0).
    function automatic logic [3:0] phase(input int e);
        return 4'((e - 1 - r0) & 15);
    endfunction

    // led_mode = {PWM, BLINK, DIRECT, OFF}, cpu_leds all ones.
    task automatic expect_leds(input int from, input int n, input logic gated,
                               input logic [3:0] duty);
        logic [3:0] c;
        logic [3:0] l;
        for (int e = from; e < from + n; e++) begin
            c    = phase(e);
            l[0] = 1'b0;
            l[1] = !gated;
            l[2] = c[3];
            l[3] = !gated && (c < duty);
`ifdef LED_LOCKLOSS_EN
            if (lockloss_exp) l[3] = c[1];
`endif
            expect_at(e, 2'd2, l, "led");
            expect_at(e, 2'd3, {3'b000, c[3]}, "hb");
        end
    endtask

    exp_t       mx;
    string      mn;
    logic [3:0] act;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
            mx = exp_q.pop_front();
            mn = name_q.pop_front();
            total++;
            if (int'(mx.cyc) < cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d not taken (now %0d)", mn, mx.cyc, cyc);
            end else begin
                case (mx.kind)
                    2'd0:    act = {3'b000, cpu_rst};
                    2'd1:    act = {2'b00, rst_state};
                    2'd2:    act = led;
                    default: act = {3'b000, hb_out};
                endcase
                if (act !== mx.val) begin
                    bad++;
                    $display("FAIL %s @cycle %0d: got %b want %b", mn, cyc, act, mx.val);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        clk_locked = 1'b1;
        btn_in     = 1'b0;
        cpu_leds   = 4'hF;
        led_mode   = 8'b11_10_01_00;
        pwm_duty   = 4'd4;

        // Reset values, then lock-to-run latency.
        wait_until(3);
        r0 = 3;
        expect_fsm(3, 2'b00, 1'b1, "reset");
        expect_at(3, 2'd2, 4'h0, "reset_led");
        expect_at(3, 2'd3, 4'h0, "reset_hb");
        rst = 1'b0;
        expect_fsm(4, 2'b01, 1'b1, "t1_wait");
        expect_fsm(19, 2'b01, 1'b1, "t1_hold15");
        expect_fsm(20, 2'b10, 1'b0, "t1_run");

        // LED modes with duty 4, then duty 0 and 15.
        expect_leds(22, 32, 1'b0, 4'd4);
        wait_until(53);
        pwm_duty = 4'd0;
        expect_leds(55, 16, 1'b0, 4'd0);
        wait_until(70);
        pwm_duty = 4'd15;
        expect_leds(72, 16, 1'b0, 4'd15);

        // Short button glitch must be rejected.
        wait_until(90);
        btn_in = 1'b1;
        for (int e = 92; e <= 108; e += 4) expect_fsm(e, 2'b10, 1'b0, "t2_pulse");
        wait_until(95);
        btn_in = 1'b0;

        // Long press forces HOLD; LED gating during reset.
        wait_until(110);
        btn_in = 1'b1;
        expect_fsm(120, 2'b10, 1'b0, "t2_pre");
        expect_fsm(121, 2'b00, 1'b1, "t2_hold");
        expect_leds(122, 9, 1'b1, 4'd15);
        wait_until(122);
        btn_in = 1'b0;
        wait_until(130);
        expect_fsm(132, 2'b00, 1'b1, "t2_held");
        expect_fsm(133, 2'b01, 1'b1, "t2_rewait");

        // Lock loss while hold_cnt=5 aborts; full hold-off after relock.
        wait_until(143);
        expect_fsm(143, 2'b01, 1'b1, "t3_cnt5");
        expect_fsm(144, 2'b00, 1'b1, "t3_abort");
        clk_locked = 1'b0;
        wait_until(144);
        clk_locked = 1'b1;
        expect_fsm(145, 2'b01, 1'b1, "t3_rewait");
        expect_fsm(160, 2'b01, 1'b1, "t3_hold15");
        expect_fsm(161, 2'b10, 1'b0, "t3_run");
        expect_leds(162, 8, 1'b0, 4'd15);

        // One-cycle lock loss in RUN.
        wait_until(170);
        clk_locked = 1'b0;
        expect_fsm(170, 2'b10, 1'b0, "t6_run");
        expect_fsm(171, 2'b00, 1'b1, "t6_hold");
        expect_fsm(172, 2'b01, 1'b1, "t6_wait");
`ifdef LED_LOCKLOSS_EN
        lockloss_exp = 1'b1;
`endif
        expect_leds(172, 17, 1'b1, 4'd15);
        expect_fsm(188, 2'b10, 1'b0, "t6_rerun");
        expect_leds(189, 16, 1'b0, 4'd15);
        wait_until(171);
        clk_locked = 1'b1;

        // Reset mid-run clears everything, including any lock-loss indication.
        wait_until(206);
        rst = 1'b1;
        expect_fsm(207, 2'b00, 1'b1, "rst_mid");
        expect_at(207, 2'd2, 4'h0, "rst_led");
        expect_at(207, 2'd3, 4'h0, "rst_hb");
        wait_until(208);
        rst = 1'b0;
        r0  = 208;
`ifdef LED_LOCKLOSS_EN
        lockloss_exp = 1'b0;
`endif
        expect_fsm(208, 2'b00, 1'b1, "rst_hold");
        expect_at(208, 2'd2, 4'h0, "rst_led2");
        expect_fsm(209, 2'b01, 1'b1, "rst_rewait");
        expect_leds(210, 15, 1'b1, 4'd15);
        expect_fsm(225, 2'b10, 1'b0, "rst_rerun");

        wait_until(226);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
